// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin write-port arbiter sharing one synchronous FIFO
//            between four producers. Grants one producer at a time for
//            bursts of up to BURST_MAX words and tracks FIFO occupancy with
//            an internal credit counter so the FIFO is never overrun.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            req[3:0]        - per-requester valid
//            data_flat       - requester i word in [i*DATA_W +: DATA_W]
//            ack[3:0]        - combinational accept (word taken this cycle)
//            grant[3:0]      - registered one-hot owner, 0 when idle
//            busy            - high while a grant is held
//            fifo_rd_ack     - one word left the FIFO, returns one credit
//            fifo_wr         - registered FIFO write strobe
//            fifo_data       - registered FIFO write data
// Options  : FIFO_ARB_STRICT0_EN - requester 0 wins every arbitration it
//            takes part in; requesters 1-3 rotate among themselves.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   data_flat,
  output logic [3:0]            ack,
  output logic [3:0]            grant,
  output logic                  busy,
  input  logic                  fifo_rd_ack,
  output logic                  fifo_wr,
  output logic [DATA_W-1:0]     fifo_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_grant, w_grant_nxt;
  logic [1:0]          r_owner, w_owner_nxt;
  logic [1:0]          r_ptr, w_ptr_nxt;
  logic [BW-1:0]       r_burst, w_burst_nxt;
  logic [CW-1:0]       r_credits;
  logic [3:0]          w_arb_req;
  logic [1:0]          w_idx;
  logic [1:0]          w_pick;
  logic                w_found;
  logic                w_hs;
  logic [DATA_W-1:0]   w_owner_data;

  assign grant        = r_grant;
  assign busy         = (r_state == ST_GRANT);
  assign w_owner_data = data_flat[r_owner*DATA_W +: DATA_W];

  // Accept uses the registered credit count: a credit returned this cycle
  // only becomes usable on the next one.
  assign ack  = (r_state == ST_GRANT) ?
                (r_grant & req & {4{r_credits != '0}}) : 4'b0000;
  assign w_hs = |ack;

  // Requester selection: search upward (mod 4) starting at pointer+1.
`ifdef FIFO_ARB_STRICT0_EN
  assign w_arb_req = req & 4'b1110;
`else
  assign w_arb_req = req;
`endif

  always_comb begin
    w_found = 1'b0;
    w_pick  = 2'd0;
    w_idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && w_arb_req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
`ifdef FIFO_ARB_STRICT0_EN
    // Requester 0 overrides the rotation; the pointer still moves on release.
    if (req[0]) begin
      w_pick = 2'd0;
    end
`endif
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_burst_nxt = r_burst;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = 4'b0001 << w_pick;
          w_owner_nxt = w_pick;
          w_burst_nxt = '0;
        end
      end
      ST_GRANT: begin
        if (!req[r_owner] ||
            (w_hs && (r_burst == BW'(BURST_MAX - 1)))) begin
          // Owner dropped its request or finished its burst.
          w_state_nxt = ST_IDLE;
          w_grant_nxt = 4'b0000;
          w_ptr_nxt   = r_owner;
        end else if (w_hs) begin
          w_burst_nxt = r_burst + BW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 4'b0000;
      end
    endcase
  end

  // State and control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= 4'b0000;
      r_owner <= 2'd0;
      r_ptr   <= 2'd3;
      r_burst <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_burst <= w_burst_nxt;
    end
  end

  // Credit counter: a handshake consumes, a read returns; both cancel.
  // Returns at full credit are dropped so the count never exceeds DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= CW'(DEPTH);
    end else if (w_hs && !fifo_rd_ack) begin
      r_credits <= r_credits - CW'(1);
    end else if (!w_hs && fifo_rd_ack && (r_credits != CW'(DEPTH))) begin
      r_credits <= r_credits + CW'(1);
    end
  end

  // FIFO write port, one cycle behind the handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wr   <= 1'b0;
      fifo_data <= '0;
    end else begin
      fifo_wr <= w_hs;
      if (w_hs) begin
        fifo_data <= w_owner_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Directed testbench for fifo_wr_arbiter. Each stimulus cycle
//            carries hand-computed ack/grant values; every expected handshake
//            pushes its word into a scoreboard that a separate monitor drains
//            whenever the DUT strobes fifo_wr.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [4*DW-1:0] data_flat;
  logic            fifo_rd_ack;
  logic [3:0]      ack;
  logic [3:0]      grant;
  logic            busy;
  logic            fifo_wr;
  logic [DW-1:0]   fifo_data;

  int              n_tests = 0;
  int              n_fail  = 0;
  logic [DW-1:0]   sb[$];
  logic [5:0]      seq = 6'd0;
  logic [3:0]      pri_exp;

  fifo_wr_arbiter #(.DATA_W(DW), .DEPTH(8), .BURST_MAX(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data_flat   (data_flat),
    .ack         (ack),
    .grant       (grant),
    .busy        (busy),
    .fifo_rd_ack (fifo_rd_ack),
    .fifo_wr     (fifo_wr),
    .fifo_data   (fifo_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && fifo_wr) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL fifo_wr_unexpected: actual fifo_wr=1 data=%0h required no write at %0t",
                 fifo_data, $time);
      end else begin
        chk("fifo_data", 32'(fifo_data), 32'(sb.pop_front()));
      end
    end
  end

  // One clock cycle: fresh data on all slices, check outputs, push expected
  // words for the handshakes this cycle, advance to just after the edge.
  task automatic cyc(input logic [3:0] ea, input logic [3:0] eg, input string nm);
    for (int i = 0; i < 4; i++) data_flat[i*DW +: DW] = {2'(i), seq};
    seq++;
    #2;
    chk({nm, "_ack"},   32'(ack),   32'(ea));
    chk({nm, "_grant"}, 32'(grant), 32'(eg));
    chk({nm, "_busy"},  32'(busy),  32'(|eg));
    for (int i = 0; i < 4; i++) if (ea[i]) sb.push_back(data_flat[i*DW +: DW]);
    @(posedge clk);
    #1;
  endtask

  // Full credits, single requester r, no returns: exactly 8 words in two
  // bursts, then the grant is held with ack low.
  task automatic drain8(input int r, input string nm);
    logic [3:0] g;
    g = 4'(1 << r);
    req = g;
    fifo_rd_ack = 1'b0;
    cyc(4'h0, 4'h0, {nm, "_arb"});
    repeat (4) cyc(g, g, {nm, "_b1"});
    cyc(4'h0, 4'h0, {nm, "_gap"});
    repeat (4) cyc(g, g, {nm, "_b2"});
    cyc(4'h0, 4'h0, {nm, "_gap2"});
    cyc(4'h0, g, {nm, "_stall"});
    cyc(4'h0, g, {nm, "_stall"});
  endtask

  task automatic release_req(input logic [3:0] g, input string nm);
    req = 4'h0;
    cyc(4'h0, g, {nm, "_drop"});
    cyc(4'h0, 4'h0, {nm, "_idle"});
  endtask

  initial begin
    rst         = 1'b1;
    req         = 4'h0;
    fifo_rd_ack = 1'b0;
    data_flat   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_busy",  32'(busy), 32'h0);
    chk("reset_ack",   32'(ack), 32'h0);
    chk("reset_fifo_wr", 32'(fifo_wr), 32'h0);
    chk("reset_fifo_data", 32'(fifo_data), 32'h0);

    // Fairness: all four requesting, credits replenished every cycle.
    req = 4'hF;
    fifo_rd_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(4'h0, 4'h0, "fair_arb");
      repeat (4) cyc(4'(1 << (k % 4)), 4'(1 << (k % 4)), "fair");
    end
    req = 4'h0;
    cyc(4'h0, 4'h0, "fair_end");

    // Single requester, 6 words: burst of 4, one idle cycle, burst of 2.
    req = 4'b0100;
    cyc(4'h0, 4'h0, "single_arb");
    repeat (4) cyc(4'b0100, 4'b0100, "single_b1");
    cyc(4'h0, 4'h0, "single_gap");
    repeat (2) cyc(4'b0100, 4'b0100, "single_b2");
    fifo_rd_ack = 1'b0;
    release_req(4'b0100, "single");

    // Credit exhaustion, then one returned credit gives exactly one word.
    drain8(1, "exh");
    fifo_rd_ack = 1'b1;
    cyc(4'h0, 4'b0010, "exh_ret");
    fifo_rd_ack = 1'b0;
    cyc(4'b0010, 4'b0010, "exh_one");
    cyc(4'h0, 4'b0010, "exh_stall3");

    // Credits at 1: handshake and return together leave credits at 1.
    fifo_rd_ack = 1'b1;
    cyc(4'h0, 4'b0010, "sim_ret");
    cyc(4'b0010, 4'b0010, "sim_both");
    fifo_rd_ack = 1'b0;
    cyc(4'b0010, 4'b0010, "sim_next");
    cyc(4'h0, 4'b0010, "sim_empty");
    release_req(4'b0010, "sim");

    // Over-return saturates at 8: exactly 8 words accepted afterwards.
    fifo_rd_ack = 1'b1;
    repeat (10) cyc(4'h0, 4'h0, "refill");
    drain8(3, "sat");
    release_req(4'b1000, "sat");
    fifo_rd_ack = 1'b1;
    repeat (10) cyc(4'h0, 4'h0, "refill2");

    // Priority: requester 1 releases with 0 and 2 pending.
`ifdef FIFO_ARB_STRICT0_EN
    pri_exp = 4'b0001;
`else
    pri_exp = 4'b0100;
`endif
    req = 4'b0010;
    cyc(4'h0, 4'h0, "pri_arb");
    cyc(4'b0010, 4'b0010, "pri_g1");
    req = 4'b0101;
    cyc(4'h0, 4'b0010, "pri_rel");
    cyc(4'h0, 4'h0, "pri_idle");
    cyc(pri_exp, pri_exp, "pri_next");
    release_req(pri_exp, "pri");

    // Asynchronous reset mid-burst with a write pending.
    req = 4'b0100;
    cyc(4'h0, 4'h0, "rst_arb");
    cyc(4'b0100, 4'b0100, "rst_hs");
    chk("rst_pre_fifo_wr", 32'(fifo_wr), 32'h1);
    chk("rst_pre_grant", 32'(grant), 32'b0100);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_grant", 32'(grant), 32'h0);
    chk("rst_async_busy", 32'(busy), 32'h0);
    chk("rst_async_ack", 32'(ack), 32'h0);
    chk("rst_async_fifo_wr", 32'(fifo_wr), 32'h0);
    chk("rst_async_fifo_data", 32'(fifo_data), 32'h0);
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    drain8(2, "post_rst");
    release_req(4'b0100, "post_rst");
    cyc(4'h0, 4'h0, "final");

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
